// File: rtl/vidcap_pkg.sv
// Shared types for the dkong video capture block: FSM states,
// packed pixel and FIFO entry layouts, default raster size.
package vidcap_pkg;
   localparam int H_ACTIVE_DEF = 256;
   localparam int V_ACTIVE_DEF = 224;
   localparam int ADDR_W_DEF   = 16;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      CAPTURE,
      FLUSH,
      DONE
   } cap_state_t;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } pix_t;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      pix_t                  pix;
   } fifo_ent_t;
endpackage

// File: rtl/vidcap_fifo.sv
// Synchronous FIFO with async active-high reset; the head is forced
// to zero while empty so the write port idles at a clean value.
module vidcap_fifo #(
   parameter int W     = 24,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == FULL_CNT);
   assign count     = r_count;
   assign w_do_pop  = pop & ~empty;
   // a full FIFO still accepts a push when the head leaves this cycle
   assign w_do_push = push & (~full | w_do_pop);
   assign dout      = empty ? '0 : r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/dkong_video_capture.sv
// Pixel stream capture into a byte framebuffer with ready/valid backpressure.
// Define DKONG_CAPTURE_ROTATE_EN for transposed (rotated monitor) addressing.
module dkong_video_capture
   import vidcap_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap_ena,
   input  logic              pix_stb,
   input  logic              video_valid,
   input  logic [2:0]        r_sig,
   input  logic [2:0]        g_sig,
   input  logic [1:0]        b_sig,
   input  logic              vblk,
   output logic              fb_wr_valid,
   input  logic              fb_wr_ready,
   output logic [ADDR_W-1:0] fb_wr_addr,
   output logic [7:0]        fb_wr_data,
   output logic              frame_done,
   output logic              overflow,
   input  logic              ovf_clr,
   output logic              busy
);
   localparam int XW = $clog2(H_ACTIVE + 1);
   localparam int YW = $clog2(V_ACTIVE + 1);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = ADDR_W + 8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      pix_t              pix;
   } ent_t;

   cap_state_t      r_state;
   cap_state_t      w_next;
   logic            r_vblk_q;
   logic            r_vv_q;
   logic [XW-1:0]   r_x;
   logic [YW-1:0]   r_y;
   logic            r_push;
   ent_t            r_ent;
   logic            r_ovf;

   logic            w_fs;
   logic            w_vrise;
   logic            w_lend;
   logic            w_take;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic            w_drop;
   logic [CW-1:0]   w_cnt;
   logic [EW-1:0]   w_dout;
   logic [ADDR_W-1:0] w_addr;

   assign w_fs    = pix_stb & r_vblk_q & ~vblk;
   assign w_vrise = pix_stb & ~r_vblk_q & vblk;
   assign w_lend  = pix_stb & r_vv_q & ~video_valid;
   assign w_take  = pix_stb & video_valid & (r_state == CAPTURE)
                  & (r_x < XW'(H_ACTIVE)) & (r_y < YW'(V_ACTIVE));

`ifdef DKONG_CAPTURE_ROTATE_EN
   assign w_addr = ADDR_W'(32'(r_x) * 32'(V_ACTIVE)
                 + 32'(V_ACTIVE - 1) - 32'(r_y));
`else
   assign w_addr = ADDR_W'(32'(r_y) * 32'(H_ACTIVE) + 32'(r_x));
`endif

   assign w_pop  = fb_wr_ready & ~w_empty;
   assign w_drop = r_push & w_full & ~w_pop;

   assign fb_wr_valid              = ~w_empty;
   assign {fb_wr_addr, fb_wr_data} = w_dout;
   assign frame_done               = (r_state == DONE);
   assign busy                     = (r_state != IDLE);
   assign overflow                 = r_ovf;

   vidcap_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (r_push),
      .din   (r_ent),
      .pop   (fb_wr_ready),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty),
      .count (w_cnt)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (cap_ena) w_next = ARMED;
         ARMED: begin
            if (!cap_ena)  w_next = IDLE;
            else if (w_fs) w_next = CAPTURE;
         end
         CAPTURE: if (w_vrise || r_y == YW'(V_ACTIVE)) w_next = FLUSH;
         // the registered push stage must be empty too, not just the FIFO
         FLUSH:   if (w_cnt == '0 && !r_push) w_next = DONE;
         DONE:    w_next = cap_ena ? ARMED : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_vblk_q <= 1'b0;
         r_vv_q   <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_push   <= 1'b0;
         r_ent    <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_push  <= w_take;
         if (w_take) begin
            r_ent.addr <= w_addr;
            r_ent.pix  <= {r_sig, g_sig, b_sig};
         end
         if (pix_stb) begin
            r_vblk_q <= vblk;
            r_vv_q   <= video_valid;
         end
         if (r_state == ARMED && w_fs) begin
            r_x <= '0;
            r_y <= '0;
         end else if (w_take) begin
            r_x <= r_x + 1'b1;
         end else if (r_state == CAPTURE && w_lend) begin
            r_x <= '0;
            if (r_y < YW'(V_ACTIVE)) r_y <= r_y + 1'b1;
         end
         if (w_drop)       r_ovf <= 1'b1;
         else if (ovf_clr) r_ovf <= 1'b0;
      end
   end
endmodule

// File: doc/dkong_video_capture.md
Name: dkong_video_capture

Overview:
- Receiving end of the video source's pixel stream.
- Samples the source's per-pixel outputs: video valid, 3/3/2-bit RGB and vertical blank.
- Rebuilds pixel coordinates from the stream itself, buffers pixels in a small FIFO, and writes each one as a byte to a framebuffer memory port with ready/valid backpressure.
- Used for scan conversion to a display path and for frame checksum/debug capture.

Parameters:
- H_ACTIVE, 256, active pixels per line.
- V_ACTIVE, 224, active lines per frame.
- FIFO_DEPTH, 16, pixel FIFO entries (power of two, min 4).
- ADDR_W, 16, framebuffer address width (must hold H_ACTIVE*V_ACTIVE).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cap_ena  in  1  capture enable (level).
- pix_stb  in  1  one-clk strobe per source pixel; sample point for the video inputs.
- video_valid  in  1  source pixel valid (high in active area).
- r_sig  in  3  red.
- g_sig  in  3  green.
- b_sig  in  2  blue.
- vblk  in  1  source vertical blank.
- fb_wr_valid  out  1  write request.
- fb_wr_ready  in  1  memory accepts the write.
- fb_wr_addr  out  ADDR_W  write address.
- fb_wr_data  out  8  pixel {r,g,b}.
- frame_done  out  1  one-clk pulse when the last pixel of a frame has been written.
- overflow  out  1  sticky: a pixel was dropped.
- ovf_clr  in  1  clears overflow.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface (already decided): one clock, clk; rst is asynchronous, active-high. All state and outputs clear on rst assertion, at any time including mid-frame.
- Reset values: fb_wr_valid=0, fb_wr_addr=0, fb_wr_data=0, frame_done=0, overflow=0, busy=0, FIFO empty, state IDLE.
- Inputs are sampled only on cycles where pix_stb=1.
- vblk falling edge (frame start) is detected from the pix_stb-sampled previous vblk value.
- State machine:
  - IDLE -> ARMED when cap_ena=1.
  - ARMED -> CAPTURE on frame start; x=0, y=0.
  - CAPTURE: each sample with video_valid=1 and x<H_ACTIVE, y<V_ACTIVE pushes {addr, data} and does x++.
  - CAPTURE: video_valid 1->0 (line end) does x=0 and y++ (saturates at V_ACTIVE).
  - CAPTURE -> FLUSH when vblk rises, or when y reaches V_ACTIVE.
  - FLUSH -> DONE when the FIFO is empty and no write is pending.
  - DONE: frame_done=1 for one clk, then -> ARMED if cap_ena=1, else IDLE.
- cap_ena deasserted during ARMED -> IDLE. Deasserted during CAPTURE/FLUSH has no effect until DONE; the frame always completes.
- Pixels with x>=H_ACTIVE in a line are discarded silently; lines beyond V_ACTIVE are discarded silently; neither sets overflow.
- Address: fb_wr_addr = y*H_ACTIVE + x, truncated to ADDR_W. Data = {r_sig, g_sig, b_sig}.
- FIFO:
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the pixel is dropped and overflow is set.
  - overflow set and ovf_clr in the same cycle: set wins.
- Output: the FIFO head drives fb_wr_*. fb_wr_valid = FIFO not empty. Pop on fb_wr_valid & fb_wr_ready.
- fb_wr_addr/fb_wr_data stay stable while fb_wr_valid=1 and fb_wr_ready=0.
- Latency: a pixel sampled at clk N appears on fb_wr_* no earlier than N+1 (registered push), with an empty FIFO and fb_wr_ready=1.
- Push and pop in the same cycle keep count unchanged. Read and write pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: DKONG_CAPTURE_ROTATE_EN.
- Defined: the address is transposed for the rotated monitor, fb_wr_addr = x*V_ACTIVE + (V_ACTIVE-1-y). The multiply is by the constant V_ACTIVE.
- Undefined: row-major address as in Behaviour. No rotation logic is synthesized.

Decomposition:
- Package vidcap_pkg holds:
  - state enum cap_state_t {IDLE, ARMED, CAPTURE, FLUSH, DONE};
  - typedef pix_t = 8-bit {r,g,b};
  - localparam default H_ACTIVE/V_ACTIVE;
  - typedef for the FIFO entry {addr, pix_t}.
- One sub-module, vidcap_fifo: synchronous FIFO with push/pop/full/empty/count and async active-high reset. The top holds the FSM, coordinate counters, edge detect and address math.

Test Plan:
- Basic frame:
  - Stimulus: cap_ena=1, fb_wr_ready=1, vblk falls, 224 lines of 256 valid pixels with data = x[7:0].
  - Required: 57344 writes, addr 0..57343 in order, frame_done pulses once, overflow=0.
- Backpressure:
  - Stimulus: fb_wr_ready held 0 for 20 pixels, FIFO_DEPTH=16.
  - Required: 16 buffered, 4 dropped, overflow=1; after ovf_clr, overflow=0. Addr/data stay stable while stalled.
- Line length:
  - Stimulus: one line of 300 valid pixels.
  - Required: only x=0..255 written; next line starts at addr 256; overflow=0.
- Enable boundary:
  - Stimulus: cap_ena dropped mid-CAPTURE.
  - Required: frame completes, frame_done pulses, then IDLE and busy=0. No writes on the next frame.
- Reset mid-frame:
  - Stimulus: rst pulsed asynchronously between clk edges during CAPTURE, 5 entries in the FIFO.
  - Required: fb_wr_valid=0 immediately and state IDLE. The next frame restarts at addr 0.
- Rotate build (DKONG_CAPTURE_ROTATE_EN):
  - Stimulus: pixel x=1, y=0.
  - Required: addr=447. Pixel x=0, y=223 gives addr=0.
